// File: rtl/simd_mac_pkg.sv
// simd_mac_pkg: shared types, lane geometry and saturation helpers
// for the SIMD multiply-accumulate pipeline.
`default_nettype none

package simd_mac_pkg;

  typedef enum logic [1:0] {
    OP_CLR = 2'd0,
    OP_MUL = 2'd1,
    OP_MAC = 2'd2,
    OP_SAT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MODE_1X  = 2'd0,
    MODE_2X  = 2'd1,
    MODE_4X  = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam int NLANES_1X = 1;
  localparam int NLANES_2X = 2;
  localparam int NLANES_4X = 4;

  // Widest accumulator the saturation helpers can describe.
  localparam int MAX_W = 128;

  function automatic int lane_w(input int data_w, input int nlanes);
    return data_w / nlanes;
  endfunction

  function automatic int guard_w(input int total_guard, input int nlanes);
    return total_guard / nlanes;
  endfunction

  // Largest positive value of a w-bit signed number, i.e. 2^(w-1)-1.
  function automatic logic signed [MAX_W-1:0] sat_max(input int w);
    logic signed [MAX_W-1:0] v;
    v        = '0;
    v[w-1]   = 1'b1;
    return v - 1;
  endfunction

  // Most negative value of a w-bit signed number, i.e. -2^(w-1).
  function automatic logic signed [MAX_W-1:0] sat_min(input int w);
    logic signed [MAX_W-1:0] v;
    v        = '0;
    v[w-1]   = 1'b1;
    return -v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simd_mac_lane.sv
// simd_mac_lane: one lane's signed multiply, guarded accumulate and
// saturate, with a sticky overflow flag.
`default_nettype none

module simd_mac_lane
  import simd_mac_pkg::*;
#(
  parameter int LW = 16,
  parameter int GL = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clr,
  input  op_e                    op,
  input  logic [LW-1:0]          a,
  input  logic [LW-1:0]          b,
  output logic [2*LW+GL-1:0]     acc,
  output logic                   ovf
);

  localparam int ACC_W = 2*LW + GL;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(2*LW));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(2*LW));

  logic signed [2*LW-1:0]  a_x;
  logic signed [2*LW-1:0]  b_x;
  logic signed [2*LW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_base;

  assign a_x    = {{LW{a[LW-1]}}, a};
  assign b_x    = {{LW{b[LW-1]}}, b};
  assign prod   = a_x * b_x;
  assign prod_x = {{GL{prod[2*LW-1]}}, prod};

  // A lane entering a new lane split starts from a clean accumulator.
  always_comb begin
    base     = acc_q;
    ovf_base = ovf;
    if (clr) begin
      base     = '0;
      ovf_base = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      case (op)
        OP_CLR: begin
          acc_q <= '0;
          ovf   <= 1'b0;
        end
        OP_MUL: begin
          acc_q <= prod_x;
          ovf   <= ovf_base;
        end
        OP_MAC: begin
          acc_q <= base + prod_x;
          ovf   <= ovf_base;
        end
        OP_SAT: begin
          if (base > SAT_HI) begin
            acc_q <= SAT_HI;
            ovf   <= 1'b1;
          end else if (base < SAT_LO) begin
            acc_q <= SAT_LO;
            ovf   <= 1'b1;
          end else begin
            acc_q <= base;
            ovf   <= ovf_base;
          end
        end
      endcase
    end
  end

  assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/simd_mac_pipe.sv
// simd_mac_pipe: two-stage signed SIMD MAC with 1/2/4 lanes, guarded
// per-lane accumulators, saturation and sticky overflow flags.
`default_nettype none

module simd_mac_pipe
  import simd_mac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic [1:0]            op,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     multiplier,
  input  logic [DATA_W-1:0]     multiplicand,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   result,
  output logic [GUARD_W-1:0]    protect,
  output logic [3:0]            ovf
);

  localparam int LW0 = lane_w(DATA_W, NLANES_1X);
  localparam int LW1 = lane_w(DATA_W, NLANES_2X);
  localparam int LW2 = lane_w(DATA_W, NLANES_4X);
  localparam int GL0 = guard_w(GUARD_W, NLANES_1X);
  localparam int GL1 = guard_w(GUARD_W, NLANES_2X);
  localparam int GL2 = guard_w(GUARD_W, NLANES_4X);

  logic              s1_valid;
  op_e               s1_op;
  mode_e             s1_mode;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  mode_e             exec_mode;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_CLR;
      s1_mode  <= MODE_1X;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op_e'(op);
        s1_mode <= (mode == 2'd3) ? MODE_1X : mode_e'(mode);
        s1_a    <= multiplier;
        s1_b    <= multiplicand;
      end
    end
  end

  logic exec;
  logic is_clr;
  logic lane_clr;

  assign exec     = s1_valid && !stall;
  assign is_clr   = (s1_op == OP_CLR);
  assign lane_clr = is_clr || (s1_mode != exec_mode);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      exec_mode <= MODE_1X;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) exec_mode <= s1_mode;
    end
  end

  // CLR touches every lane; other ops only the lanes of their own split.
  logic en_m0, en_m1, en_m2;
  assign en_m0 = exec && (is_clr || s1_mode == MODE_1X);
  assign en_m1 = exec && (is_clr || s1_mode == MODE_2X);
  assign en_m2 = exec && (is_clr || s1_mode == MODE_4X);

  logic [2*LW0+GL0-1:0] acc_m0;
  logic                 ovf_m0;
  logic [2*DATA_W-1:0]  res_m1, res_m2;
  logic [GUARD_W-1:0]   prot_m1, prot_m2;
  logic [1:0]           ovf_m1;
  logic [3:0]           ovf_m2;

  simd_mac_lane #(.LW(LW0), .GL(GL0)) u_lane_m0 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en_m0),
    .clr     (lane_clr),
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .acc     (acc_m0),
    .ovf     (ovf_m0)
  );

  for (genvar i = 0; i < NLANES_2X; i++) begin : g_m1_lane
    logic [2*LW1+GL1-1:0] acc;
    simd_mac_lane #(.LW(LW1), .GL(GL1)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en_m1),
      .clr     (lane_clr),
      .op      (s1_op),
      .a       (s1_a[i*LW1 +: LW1]),
      .b       (s1_b[i*LW1 +: LW1]),
      .acc     (acc),
      .ovf     (ovf_m1[i])
    );
    assign res_m1[i*2*LW1 +: 2*LW1] = acc[2*LW1-1:0];
    assign prot_m1[i*GL1 +: GL1]    = acc[2*LW1+GL1-1 -: GL1];
  end

  for (genvar i = 0; i < NLANES_4X; i++) begin : g_m2_lane
    logic [2*LW2+GL2-1:0] acc;
    simd_mac_lane #(.LW(LW2), .GL(GL2)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en_m2),
      .clr     (lane_clr),
      .op      (s1_op),
      .a       (s1_a[i*LW2 +: LW2]),
      .b       (s1_b[i*LW2 +: LW2]),
      .acc     (acc),
      .ovf     (ovf_m2[i])
    );
    assign res_m2[i*2*LW2 +: 2*LW2] = acc[2*LW2-1:0];
    assign prot_m2[i*GL2 +: GL2]    = acc[2*LW2+GL2-1 -: GL2];
  end

  // Select is the registered split of the last executed op, so outputs
  // only change on the edge that updates the accumulators.
  always_comb begin
    result  = acc_m0[2*LW0-1:0];
    protect = acc_m0[2*LW0+GL0-1 -: GL0];
    ovf     = {3'b000, ovf_m0};
    case (exec_mode)
      MODE_2X: begin
        result  = res_m1;
        protect = prot_m1;
        ovf     = {2'b00, ovf_m1};
      end
      MODE_4X: begin
        result  = res_m2;
        protect = prot_m2;
        ovf     = ovf_m2;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_mac_pipe.sv
// tb_simd_mac_pipe: table vectors plus scoreboard-checked MAC streams
// for simd_mac_pipe at DATA_W=16, GUARD_W=8.
`timescale 1ns/1ps
`default_nettype none

module tb_simd_mac_pipe;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, stall;
  logic [1:0]  op, mode;
  logic [15:0] multiplier, multiplicand;
  logic        out_valid;
  logic [31:0] result;
  logic [7:0]  protect;
  logic [3:0]  ovf;

  always #5 clk = ~clk;

  simd_mac_pipe #(.DATA_W(16), .GUARD_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .stall        (stall),
    .op           (op),
    .mode         (mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .out_valid    (out_valid),
    .result       (result),
    .protect      (protect),
    .ovf          (ovf)
  );

  typedef struct {
    logic [31:0] res;
    logic [7:0]  prot;
    logic [3:0]  ovf;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [7:0]  prot;
    logic [3:0]  ovf;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;
  logic  last_stall = 1'b0;

  longint macc[4];
  bit     movf[4];
  int     mmode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      macc[i] = 0;
      movf[i] = 1'b0;
    end
    mmode = 0;
  endtask

  // Reference behaviour: lanes of the current split only; a split change
  // or CLR starts every lane from zero.
  task automatic model_op(input logic [1:0] o, input logic [1:0] md,
                          input logic [15:0] a, input logic [15:0] b, output exp_t e);
    int m, lw, gl, aw;
    longint pa, pb, pr, hi, lo;
    m  = (md == 2'd3) ? 0 : int'(md);
    lw = 16 >> m;
    gl = 8 >> m;
    aw = 2*lw + gl;
    if (o == 2'd0 || m != mmode) begin
      for (int i = 0; i < 4; i++) begin
        macc[i] = 0;
        movf[i] = 1'b0;
      end
    end
    mmode  = m;
    e.res  = '0;
    e.prot = '0;
    e.ovf  = '0;
    hi = (longint'(1) <<< (2*lw - 1)) - 1;
    lo = -hi - 1;
    for (int i = 0; i < (1 << m); i++) begin
      pa = sx(longint'(a >> (i*lw)), lw);
      pb = sx(longint'(b >> (i*lw)), lw);
      pr = pa * pb;
      case (o)
        2'd1: macc[i] = sx(pr, aw);
        2'd2: macc[i] = sx(macc[i] + pr, aw);
        2'd3: begin
          if (macc[i] > hi) begin macc[i] = hi; movf[i] = 1'b1; end
          else if (macc[i] < lo) begin macc[i] = lo; movf[i] = 1'b1; end
        end
        default: ;
      endcase
      e.res  = e.res  | (32'(macc[i] & ((longint'(1) <<< (2*lw)) - 1)) << (i*2*lw));
      e.prot = e.prot | (8'((macc[i] >>> (2*lw)) & ((longint'(1) <<< gl) - 1)) << (i*gl));
      e.ovf[i] = movf[i];
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [1:0] md,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid     = 1'b1;
    op           = o;
    mode         = md;
    multiplier   = a;
    multiplicand = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] md,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    model_op(o, md, a, b, e);
    sb.push_back(e);
    drive(o, md, a, b);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk) last_stall <= stall;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && reset_n && out_valid && !last_stall) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
      end else begin
        e = sb.pop_front();
        check("result",  result,        e.res);
        check("protect", 32'(protect),  32'(e.prot));
        check("ovf",     32'(ovf),      32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
    op = 2'd0; mode = 2'd0; multiplier = '0; multiplicand = '0;
    model_reset();

    // op, mode, multiplier, multiplicand, result, protect, ovf
    vecs.push_back('{2'd1, 2'd0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8'h00, 4'h0});
    vecs.push_back('{2'd1, 2'd0, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 8'hFF, 4'h0});
    vecs.push_back('{2'd1, 2'd0, 16'h8000, 16'h8000, 32'h40000000, 8'h00, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'h8000, 16'h8000, 32'h80000000, 8'h00, 4'h0});
    vecs.push_back('{2'd3, 2'd0, 16'h0000, 16'h0000, 32'h7FFFFFFF, 8'h00, 4'h1});
    vecs.push_back('{2'd1, 2'd1, 16'h7F80, 16'h7F80, 32'h3F014000, 8'h00, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'h7F80, 16'h7F80, 32'h3F804000, 8'h00, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'hFFFF, 16'h0001, 32'h3F803FFF, 8'h00, 4'h0});
    vecs.push_back('{2'd0, 2'd0, 16'h1234, 16'h5678, 32'h00000000, 8'h00, 4'h0});
    vecs.push_back('{2'd1, 2'd2, 16'h8421, 16'h7777, 32'hC81C0E07, 8'hC0, 4'h0});
    vecs.push_back('{2'd3, 2'd2, 16'h0000, 16'h0000, 32'hC81C0E07, 8'hC0, 4'h0});
    vecs.push_back('{2'd2, 2'd2, 16'h8888, 16'h8888, 32'h085C4E47, 8'h00, 4'h0});
    vecs.push_back('{2'd2, 2'd2, 16'h8888, 16'h8888, 32'h489C8E87, 8'h00, 4'h0});
    vecs.push_back('{2'd3, 2'd2, 16'h0000, 16'h0000, 32'h487F7F7F, 8'h00, 4'h7});
    vecs.push_back('{2'd1, 2'd3, 16'h0003, 16'hFFFE, 32'hFFFFFFFA, 8'hFF, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'h0002, 16'h0002, 32'hFFFFFFFE, 8'hFF, 4'h0});
    vecs.push_back('{2'd1, 2'd0, 16'h8000, 16'h7FFF, 32'hC0008000, 8'hFF, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'h8000, 16'h7FFF, 32'h80010000, 8'hFF, 4'h0});
    vecs.push_back('{2'd2, 2'd0, 16'h8000, 16'h7FFF, 32'h40018000, 8'hFF, 4'h0});
    vecs.push_back('{2'd3, 2'd0, 16'h0000, 16'h0000, 32'h80000000, 8'hFF, 4'h1});

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result",    result,         32'd0);
    check("reset_protect",   32'(protect),   32'd0);
    check("reset_ovf",       32'(ovf),       32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Table vectors, back to back; the model tracks state alongside.
    for (int i = 0; i < vecs.size(); i++) begin
      model_op(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, e);
      sb.push_back('{vecs[i].res, vecs[i].prot, vecs[i].ovf});
      drive(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b);
    end
    drain();

    // Single op: two-edge latency and a one-cycle out_valid pulse.
    issue(2'd1, 2'd0, 16'h0003, 16'h0005);
    @(negedge clk);
    check("pulse_pre", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("pulse_on", 32'(out_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("pulse_len",   32'(out_valid), 32'd0);
    check("bubble_hold", result,         32'h0000000F);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a MAC stream.
    mon_en = 1'b0;
    drive(2'd2, 2'd0, 16'h1000, 16'h1000);
    drive(2'd2, 2'd0, 16'h1000, 16'h1000);
    in_valid = 1'b1; op = 2'd2; mode = 2'd0;
    reset_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result",    result,         32'd0);
    check("midrst_protect",   32'(protect),   32'd0);
    check("midrst_ovf",       32'(ovf),       32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_no_leak", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Stall for three cycles between two MACs of a stream.
    issue(2'd0, 2'd0, 16'h0000, 16'h0000);
    issue(2'd1, 2'd0, 16'h0010, 16'h0010);
    issue(2'd2, 2'd0, 16'h0020, 16'h0003);
    issue(2'd2, 2'd0, 16'h0005, 16'h0005);
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_result",    result,         32'h00000160);
      check("stall_protect",   32'(protect),   32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    drain();
    check("stall_final", result, 32'h00000179);

    // Random MAC-heavy stream with occasional split changes.
    begin
      logic [1:0] cur_mode, o;
      int r;
      cur_mode = 2'd1;
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 7) == 0) cur_mode = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 15);
        o = (r == 0) ? 2'd0 : (r < 3) ? 2'd1 : (r < 13) ? 2'd2 : 2'd3;
        issue(o, cur_mode, 16'($urandom), 16'($urandom));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
